// File: rtl/markov_table_merge.sv
// markov_table_merge: merges Markov transition lists A and B of {key,count} into an internal output table
//
// Ports:
//   clk, reset           clock (posedge) and synchronous active-high reset
//   start                1-cycle pulse, begins a merge when idle
//   a_len, b_len         list lengths, sampled on an accepted start
//   a_addr/a_data        list A sync-RAM read port (data valid 1 cycle after addr)
//   b_addr/b_data        list B sync-RAM read port (data valid 1 cycle after addr)
//   out_addr             output table readback index
//   out_key, out_cnt     combinational readback, 0 when out_addr >= out_len
//   out_len              valid entries in the output table
//   busy, done           merge in progress / 1-cycle completion pulse
//   overflow, sat        sticky drop and saturation flags, cleared on start
// Build option: define MARKOV_SAT_EN to saturate counts (otherwise counts wrap and sat stays 0).
module markov_table_merge #(
   parameter int KEY_W  = 16,
   parameter int CNT_W  = 8,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       a_len,
   input  logic [ADDR_W-1:0]       b_len,
   output logic [ADDR_W-1:0]       a_addr,
   input  logic [KEY_W+CNT_W-1:0]  a_data,
   output logic [ADDR_W-1:0]       b_addr,
   input  logic [KEY_W+CNT_W-1:0]  b_data,
   input  logic [ADDR_W-1:0]       out_addr,
   output logic [KEY_W-1:0]        out_key,
   output logic [CNT_W-1:0]        out_cnt,
   output logic [ADDR_W-1:0]       out_len,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic                    sat
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LMAX = ADDR_W'(DEPTH);
   typedef enum logic [2:0] {IDLE, COPY_A, FETCH_B, SEARCH, INCREMENT, APPEND, FINISH} state_t;
   state_t            r_state;
   logic [ADDR_W-1:0] r_a_len, r_b_len, r_len, r_i, r_j, r_a_addr, r_b_addr;
   logic              r_ph, r_busy, r_done, r_ovf, r_sat;
   logic [KEY_W-1:0]  r_bkey;
   logic [CNT_W-1:0]  r_bcnt;
   logic [KEY_W-1:0]  r_key [DEPTH];
   logic [CNT_W-1:0]  r_cnt [DEPTH];
   logic              w_we, w_hit, w_last, w_sat;
   logic [ADDR_W-1:0] w_im1;
   logic [IW-1:0]     w_wa;
   logic [KEY_W-1:0]  w_wkey;
   logic [CNT_W-1:0]  w_wcnt, w_new;
`ifdef MARKOV_SAT_EN
   logic [CNT_W:0]    w_sum;
`endif
   assign a_addr   = r_a_addr;
   assign b_addr   = r_b_addr;
   assign out_len  = r_len;
   assign busy     = r_busy;
   assign done     = r_done;
   assign overflow = r_ovf;
   assign sat      = r_sat;
   assign out_key  = out_addr < r_len ? r_key[out_addr[IW-1:0]] : '0;
   assign out_cnt  = out_addr < r_len ? r_cnt[out_addr[IW-1:0]] : '0;
   always_comb begin
`ifdef MARKOV_SAT_EN
      w_sum  = {1'b0, r_cnt[r_i[IW-1:0]]} + {1'b0, r_bcnt};
      w_new  = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      w_sat  = w_sum[CNT_W];
`else
      w_new  = r_cnt[r_i[IW-1:0]] + r_bcnt;
      w_sat  = 1'b0;
`endif
      w_hit  = r_key[r_i[IW-1:0]] == r_bkey;
      w_last = r_i == r_len - 1'b1;
      w_im1  = r_i - 1'b1;
      // COPY_A writes the word fetched last cycle, hence index r_i-1
      w_we   = !reset && ((r_state == COPY_A && r_i != '0) || r_state == INCREMENT ||
                          (r_state == APPEND && r_len < LMAX));
      w_wa   = r_state == COPY_A ? w_im1[IW-1:0] : r_state == APPEND ? r_len[IW-1:0] : r_i[IW-1:0];
      w_wkey = r_state == COPY_A ? a_data[KEY_W+CNT_W-1:CNT_W] : r_bkey;
      w_wcnt = r_state == COPY_A ? a_data[CNT_W-1:0] : r_state == INCREMENT ? w_new : r_bcnt;
   end
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_key[w_wa] <= w_wkey;
         r_cnt[w_wa] <= w_wcnt;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_len    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_sat    <= 1'b0;
         r_a_addr <= '0;
         r_b_addr <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_a_len  <= a_len > LMAX ? LMAX : a_len;
               r_b_len  <= b_len > LMAX ? LMAX : b_len;
               r_ovf    <= a_len > LMAX || b_len > LMAX;
               r_sat    <= 1'b0;
               r_len    <= '0;
               r_busy   <= 1'b1;
               r_i      <= '0;
               r_a_addr <= '0;
               r_state  <= COPY_A;
            end
            COPY_A: if (r_i == r_a_len) begin
               r_len    <= r_a_len;
               r_j      <= '0;
               r_ph     <= 1'b0;
               r_b_addr <= '0;
               r_state  <= FETCH_B;
            end else begin
               r_i      <= r_i + 1'b1;
               r_a_addr <= r_i + 1'b1;
            end
            // b_addr already holds j on entry, so phase 1 sees B[j] on b_data
            FETCH_B: if (r_j == r_b_len) begin
               r_done  <= 1'b1;
               r_state <= FINISH;
            end else if (!r_ph) begin
               r_ph <= 1'b1;
            end else begin
               r_ph    <= 1'b0;
               r_bkey  <= b_data[KEY_W+CNT_W-1:CNT_W];
               r_bcnt  <= b_data[CNT_W-1:0];
               r_i     <= '0;
               r_state <= r_len == '0 ? APPEND : SEARCH;
            end
            SEARCH: if (w_hit) begin
               r_state <= INCREMENT;
            end else if (w_last) begin
               r_state <= APPEND;
            end else begin
               r_i <= r_i + 1'b1;
            end
            INCREMENT: begin
               r_sat    <= r_sat | w_sat;
               r_j      <= r_j + 1'b1;
               r_b_addr <= r_j + 1'b1;
               r_state  <= FETCH_B;
            end
            APPEND: begin
               if (r_len < LMAX) r_len <= r_len + 1'b1;
               else r_ovf <= 1'b1;
               r_j      <= r_j + 1'b1;
               r_b_addr <= r_j + 1'b1;
               r_state  <= FETCH_B;
            end
            FINISH: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_markov_table_merge.sv
// tb_markov_table_merge: directed vectors, corner sequences and randomized merges against a queue-based model
module tb_markov_table_merge;
   localparam int D  = 8;
   localparam int AW = 4;
`ifdef MARKOV_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   typedef struct {
      int al, bl;
      logic [23:0] a0, a1, a2, b0, b1, b2;
      int elen;
      logic [23:0] e0, e1, e2;
      bit eovf, esat;
      int ecyc;
   } vec_t;
   logic clk = 1'b0;
   logic reset, start;
   logic [AW-1:0] a_len, b_len, a_addr, b_addr, out_addr, out_len;
   logic [23:0] a_data, b_data;
   logic [15:0] out_key;
   logic [7:0] out_cnt;
   logic busy, done, overflow, sat;
   logic [23:0] mem_a [16];
   logic [23:0] mem_b [16];
   int checks = 0, errors = 0, tag = 0;
   int exp_len, exp_cyc;
   bit exp_ovf, exp_sat;
   logic [23:0] exp_e [D];
   vec_t vt [5];

   always #5 clk = ~clk;
   always @(posedge clk) begin
      a_data <= mem_a[a_addr];
      b_data <= mem_b[b_addr];
   end

   markov_table_merge #(.KEY_W(16), .CNT_W(8), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .start(start), .a_len(a_len), .b_len(b_len),
      .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
      .out_addr(out_addr), .out_key(out_key), .out_cnt(out_cnt), .out_len(out_len),
      .busy(busy), .done(done), .overflow(overflow), .sat(sat));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s tag=%0d got=%0h want=%0h", nm, tag, act, exp);
      end
   endtask

   // Reference: plain list merge with first-match search, plus cycle cost from the documented timing.
   task automatic model(input int al, input int bl);
      logic [15:0] qk[$];
      int qc[$];
      int na, nb, idx, s;
      na = al > D ? D : al;
      nb = bl > D ? D : bl;
      exp_ovf = (al > D) || (bl > D);
      exp_sat = 1'b0;
      exp_cyc = na + 3;
      for (int i = 0; i < na; i++) begin
         qk.push_back(mem_a[i][23:8]);
         qc.push_back(int'(mem_a[i][7:0]));
      end
      for (int j = 0; j < nb; j++) begin
         idx = -1;
         for (int i = 0; i < qk.size(); i++)
            if (idx < 0 && qk[i] == mem_b[j][23:8]) idx = i;
         if (idx >= 0) begin
            s = qc[idx] + int'(mem_b[j][7:0]);
            if (SAT && s > 255) begin
               qc[idx] = 255;
               exp_sat = 1'b1;
            end else qc[idx] = s % 256;
            exp_cyc += idx + 4;
         end else begin
            exp_cyc += qk.size() + 3;
            if (qk.size() < D) begin
               qk.push_back(mem_b[j][23:8]);
               qc.push_back(int'(mem_b[j][7:0]));
            end else exp_ovf = 1'b1;
         end
      end
      exp_len = qk.size();
      for (int i = 0; i < D; i++) begin
         exp_e[i] = '0;
         if (i < exp_len) exp_e[i] = {qk[i], 8'(qc[i])};
      end
   endtask

   task automatic run_merge(input int al, input int bl, input int restart_at);
      int cyc;
      @(negedge clk);
      a_len = AW'(al);
      b_len = AW'(bl);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      chk("busy_after_start", busy, 1);
      while (!done && cyc < 600) begin
         start = (cyc == restart_at);
         if (start) begin
            a_len = '0;
            b_len = '0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("done_cycle", cyc, exp_cyc);
      chk("busy_at_done", busy, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("out_len", out_len, exp_len);
      chk("overflow", overflow, exp_ovf);
      chk("sat", sat, exp_sat);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         out_addr = AW'(i);
         #2;
         chk("table", {out_key, out_cnt}, i < exp_len ? exp_e[i] : 24'h0);
      end
   endtask

   task automatic load_vec(input int v);
      mem_a[0] = vt[v].a0; mem_a[1] = vt[v].a1; mem_a[2] = vt[v].a2;
      mem_b[0] = vt[v].b0; mem_b[1] = vt[v].b1; mem_b[2] = vt[v].b2;
      exp_len = vt[v].elen;
      exp_ovf = vt[v].eovf;
      exp_sat = vt[v].esat;
      exp_cyc = vt[v].ecyc;
      for (int i = 0; i < D; i++) exp_e[i] = '0;
      exp_e[0] = vt[v].e0; exp_e[1] = vt[v].e1; exp_e[2] = vt[v].e2;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog tag=%0d", tag);
      $fatal(1);
   end

   initial begin
      bit seen;
      vt[0] = '{2, 2, 24'h000503, 24'h000701, 24'h0, 24'h000702, 24'h000904, 24'h0,
                3, 24'h000503, 24'h000703, 24'h000904, 1'b0, 1'b0, 15};
      vt[1] = '{0, 0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0,
                0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0, 3};
      vt[2] = '{1, 1, 24'h0001FA, 24'h0, 24'h0, 24'h00010A, 24'h0, 24'h0,
                1, SAT ? 24'h0001FF : 24'h000104, 24'h0, 24'h0, 1'b0, SAT, 8};
      vt[3] = '{0, 3, 24'h0, 24'h0, 24'h0, 24'h000301, 24'h000301, 24'h000301,
                1, 24'h000303, 24'h0, 24'h0, 1'b0, 1'b0, 14};
      vt[4] = '{1, 1, 24'h000205, 24'h0, 24'h0, 24'h000400, 24'h0, 24'h0,
                2, 24'h000205, 24'h000400, 24'h0, 1'b0, 1'b0, 8};
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      reset = 1'b1; start = 1'b0; a_len = '0; b_len = '0; out_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_sat", sat, 0);
      chk("rst_len", out_len, 0);
      chk("rst_addr", {a_addr, b_addr}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      for (int v = 0; v < 5; v++) begin
         tag = v;
         load_vec(v);
         run_merge(vt[v].al, vt[v].bl, 0);
      end

      // start while busy must not restart the merge
      tag = 10;
      load_vec(0);
      run_merge(2, 2, 4);

      // full table: a new key is dropped, an existing key still merges
      tag = 20;
      for (int i = 0; i < 16; i++) mem_a[i] = {16'(10 + i), 8'd1};
      mem_b[0] = {16'd99, 8'd1};
      exp_len = 8; exp_ovf = 1'b1; exp_sat = 1'b0; exp_cyc = 22;
      for (int i = 0; i < D; i++) exp_e[i] = mem_a[i];
      run_merge(8, 1, 0);
      tag = 21;
      mem_b[0] = {16'd12, 8'd2};
      exp_ovf = 1'b0; exp_cyc = 17; exp_e[2] = {16'd12, 8'd3};
      run_merge(8, 1, 0);
      tag = 22;
      exp_ovf = 1'b1; exp_cyc = 11; exp_e[2] = mem_a[2];
      run_merge(9, 0, 0);

      // reset in SEARCH abandons the merge
      tag = 30;
      load_vec(0);
      @(negedge clk);
      a_len = 2; b_len = 2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_len", out_len, 0);
      chk("rstmid_done", done, 0);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("rstmid_no_done", seen, 0);
      tag = 31;
      run_merge(2, 2, 0);

      for (int t = 0; t < 40; t++) begin
         int al, bl;
         tag = 100 + t;
         al = $urandom_range(0, 9);
         bl = $urandom_range(0, 9);
         for (int i = 0; i < 16; i++) begin
            mem_a[i] = {16'($urandom_range(0, 5)), 8'($urandom_range(0, 255))};
            mem_b[i] = {16'($urandom_range(0, 6)), 8'($urandom_range(0, 255))};
         end
         model(al, bl);
         run_merge(al, bl, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
